// File: rtl/i2s_pkg.sv
`timescale 1ns/1ps
// Shared I2S definitions for the receive and transmit sides: frame-tracking
// states and default word/slot geometry.
package i2s_pkg;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_DELAY = 2'd1,
    ST_SHIFT = 2'd2,
    ST_PAD   = 2'd3
  } i2s_state_e;

  localparam int I2S_DATA_WIDTH = 24;
  localparam int I2S_SLOT_WIDTH = 32;

endpackage

// File: rtl/i2s_edge_sync.sv
`timescale 1ns/1ps
// Two-flop synchronizer followed by an edge-detect register; rise is a
// single-cycle pulse for each rising edge of the asynchronous input d.
module i2s_edge_sync (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic rise
);

  logic sync1_reg;
  logic sync2_reg;
  logic dly_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      dly_reg   <= 1'b0;
    end else begin
      sync1_reg <= d;
      sync2_reg <= sync1_reg;
      dly_reg   <= sync2_reg;
    end
  end

  assign rise = sync2_reg & ~dly_reg;

endmodule

// File: rtl/i2s_slave_rx.sv
`timescale 1ns/1ps
// I2S slave receiver: oversamples sclk/ws/sd on mclk and presents stereo pairs
// with a valid/ready handshake. Define I2S_RX_FRAME_CHECK_EN for frame_err.
module i2s_slave_rx
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = I2S_DATA_WIDTH,
  parameter int SLOT_WIDTH = I2S_SLOT_WIDTH
) (
  input  logic                  mclk,
  input  logic                  rst,
  input  logic                  sclk_in,
  input  logic                  ws_in,
  input  logic                  sd_in,
  output logic [DATA_WIDTH-1:0] left_data,
  output logic [DATA_WIDTH-1:0] right_data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(SLOT_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH);

  logic       sclk_rise;
  logic [1:0] aux_in;
  logic [1:0] aux_dly;
  logic       ws_bit;
  logic       sd_bit;

  i2s_edge_sync u_sclk_sync (
    .clk  (mclk),
    .srst (rst),
    .d    (sclk_in),
    .rise (sclk_rise)
  );

  // ws and sd get the same three-stage depth as sclk so they line up with the tick.
  assign aux_in = {ws_in, sd_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_aux_sync
      logic s1_reg;
      logic s2_reg;
      logic dly_reg;
      always_ff @(posedge mclk) begin
        if (rst) begin
          s1_reg  <= 1'b0;
          s2_reg  <= 1'b0;
          dly_reg <= 1'b0;
        end else begin
          s1_reg  <= aux_in[gi];
          s2_reg  <= s1_reg;
          dly_reg <= s2_reg;
        end
      end
      assign aux_dly[gi] = dly_reg;
    end
  endgenerate

  assign ws_bit = aux_dly[1];
  assign sd_bit = aux_dly[0];

  i2s_state_e            state_reg;
  logic                  chan_reg;
  logic                  ws_prev_reg;
  logic                  left_done_reg;
  logic                  pair_done_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [CNT_W-1:0]      count_inc;
  logic [DATA_WIDTH-1:0] left_sh_reg;
  logic [DATA_WIDTH-1:0] right_sh_reg;
  logic [DATA_WIDTH-1:0] left_data_reg;
  logic [DATA_WIDTH-1:0] right_data_reg;
  logic                  valid_reg;
  logic                  overrun_reg;
  logic                  frame_slip;
  logic                  shift_en;

  assign count_inc  = count_reg + 1'b1;
  assign frame_slip = sclk_rise && (state_reg == ST_SHIFT) && (ws_bit != chan_reg);
  // The MSB arrives on the tick after the ws change, so DELAY already captures it.
  assign shift_en   = sclk_rise &&
                      ((state_reg == ST_DELAY) || ((state_reg == ST_SHIFT) && !frame_slip));

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_reg     <= ST_SYNC;
      chan_reg      <= 1'b0;
      ws_prev_reg   <= 1'b0;
      left_done_reg <= 1'b0;
      pair_done_reg <= 1'b0;
      count_reg     <= '0;
    end else begin
      pair_done_reg <= 1'b0;
      if (sclk_rise) begin
        ws_prev_reg <= ws_bit;
        case (state_reg)
          ST_SYNC: begin
            if (ws_prev_reg && !ws_bit) begin
              state_reg <= ST_DELAY;
              chan_reg  <= 1'b0;
            end
          end
          ST_DELAY: begin
            state_reg <= ST_SHIFT;
            count_reg <= CNT_W'(1);
          end
          ST_SHIFT: begin
            if (frame_slip) begin
              state_reg     <= ST_DELAY;
              chan_reg      <= ws_bit;
              left_done_reg <= 1'b0;
            end else begin
              count_reg <= count_inc;
              if (count_inc == LAST_CNT) begin
                state_reg <= ST_PAD;
                if (!chan_reg) begin
                  left_done_reg <= 1'b1;
                end else begin
                  pair_done_reg <= left_done_reg;
                  left_done_reg <= 1'b0;
                end
              end
            end
          end
          ST_PAD: begin
            if (ws_bit != chan_reg) begin
              state_reg <= ST_DELAY;
              chan_reg  <= ws_bit;
            end
          end
          default: state_reg <= ST_SYNC;
        endcase
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      left_sh_reg  <= '0;
      right_sh_reg <= '0;
    end else if (shift_en) begin
      if (!chan_reg) begin
        left_sh_reg <= {left_sh_reg[DATA_WIDTH-2:0], sd_bit};
      end else begin
        right_sh_reg <= {right_sh_reg[DATA_WIDTH-2:0], sd_bit};
      end
    end
  end

  // A new pair always wins over a same-cycle handshake; overrun only when it was unconsumed.
  always_ff @(posedge mclk) begin
    if (rst) begin
      left_data_reg  <= '0;
      right_data_reg <= '0;
      valid_reg      <= 1'b0;
      overrun_reg    <= 1'b0;
    end else if (pair_done_reg) begin
      left_data_reg  <= left_sh_reg;
      right_data_reg <= right_sh_reg;
      valid_reg      <= 1'b1;
      if (valid_reg && !ready) begin
        overrun_reg <= 1'b1;
      end
    end else if (valid_reg && ready) begin
      valid_reg <= 1'b0;
    end
  end

`ifdef I2S_RX_FRAME_CHECK_EN
  logic frame_err_reg;

  always_ff @(posedge mclk) begin
    if (rst) begin
      frame_err_reg <= 1'b0;
    end else if (frame_slip) begin
      frame_err_reg <= 1'b1;
    end
  end

  assign frame_err = frame_err_reg;
`else
  assign frame_err = 1'b0;
`endif

  assign left_data  = left_data_reg;
  assign right_data = right_data_reg;
  assign valid      = valid_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_i2s_slave_rx.sv
`timescale 1ns/1ps
// Self-checking bench for i2s_slave_rx: bit-level I2S master at mclk/sclk = 4
// and a slot-level reference model that derives expected stereo pairs.
module tb_i2s_slave_rx;

  localparam int DW = 24;
  localparam int SW = 32;
`ifdef I2S_RX_FRAME_CHECK_EN
  localparam bit FE_EXP = 1'b1;
`else
  localparam bit FE_EXP = 1'b0;
`endif

  logic          mclk = 1'b0;
  logic          rst = 1'b1;
  logic          sclk_in = 1'b0;
  logic          ws_in = 1'b0;
  logic          sd_in = 1'b0;
  logic          ready = 1'b0;
  logic [DW-1:0] left_data;
  logic [DW-1:0] right_data;
  logic          valid;
  logic          overrun;
  logic          frame_err;

  int            n_cmp = 0;
  int            n_bad = 0;
  bit            stim_ws[$];
  bit            stim_sd[$];
  int            sent_n = 0;
  logic [DW-1:0] exp_l[$];
  logic [DW-1:0] exp_r[$];
  logic [DW-1:0] cap_l[$];
  logic [DW-1:0] cap_r[$];
  int            valid_cycles = 0;
  bit            rand_ready = 1'b0;

  always #5 mclk = ~mclk;

  i2s_slave_rx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW)) dut (
    .mclk       (mclk),
    .rst        (rst),
    .sclk_in    (sclk_in),
    .ws_in      (ws_in),
    .sd_in      (sd_in),
    .left_data  (left_data),
    .right_data (right_data),
    .valid      (valid),
    .ready      (ready),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  // Handshake monitor: valid && ready seen here completes at the next rising edge.
  always @(negedge mclk) begin
    if (!rst) begin
      if (valid) valid_cycles++;
      if (valid && ready) begin
        cap_l.push_back(left_data);
        cap_r.push_back(right_data);
        $display("[%0t] pair accepted: left=%h right=%h", $time, left_data, right_data);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_stream();
    stim_ws.delete();
    stim_sd.delete();
    sent_n = 0;
    cap_l.delete();
    cap_r.delete();
    valid_cycles = 0;
  endtask

  // One ws run: index 0 is the delay bit, 1..DW carry the word MSB first, the rest is random pad.
  task automatic add_run(input bit w, input int len, input logic [DW-1:0] word);
    for (int k = 0; k < len; k++) begin
      stim_ws.push_back(w);
      if (k >= 1 && k <= DW) stim_sd.push_back(word[DW-k]);
      else                   stim_sd.push_back(1'($urandom_range(0, 1)));
    end
  endtask

  task automatic add_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    add_run(1'b0, SW, l);
    add_run(1'b1, SW, r);
  endtask

  task automatic send_bit(input bit w, input bit d);
    for (int p = 0; p < 4; p++) begin
      @(posedge mclk); #1;
      if (p == 0) begin
        sclk_in = 1'b0;
        ws_in   = w;
        sd_in   = d;
      end
      if (p == 2) sclk_in = 1'b1;
      if (rand_ready) ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_pending();
    while (sent_n < stim_ws.size()) begin
      send_bit(stim_ws[sent_n], stim_sd[sent_n]);
      sent_n++;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sclk_in = 1'b0; ws_in = 1'b0; sd_in = 1'b0;
    ready = 1'b0; rand_ready = 1'b0;
    repeat (3) @(posedge mclk);
    #1;
    rst = 1'b0;
    clear_stream();
  endtask

  // Reference model over ws runs: slots count only after a ws 1->0 change, a slot is a
  // word when it holds delay+DW bits, and a right word pairs only with the left just before it.
  task automatic build_expected();
    int i, j, n;
    bit armed, have_left, prev;
    logic [DW-1:0] word, left_word;
    exp_l.delete();
    exp_r.delete();
    armed = 0; have_left = 0; prev = 0; left_word = '0;
    n = stim_ws.size();
    i = 0;
    while (i < n) begin
      j = i;
      while (j < n && stim_ws[j] == stim_ws[i]) j++;
      if (prev && !stim_ws[i]) armed = 1;
      if (armed) begin
        if (j - i >= DW + 1) begin
          word = '0;
          for (int k = 1; k <= DW; k++) word = {word[DW-2:0], stim_sd[i+k]};
          if (!stim_ws[i]) begin
            left_word = word;
            have_left = 1;
          end else begin
            if (have_left) begin
              exp_l.push_back(left_word);
              exp_r.push_back(word);
            end
            have_left = 0;
          end
        end else begin
          have_left = 0;
        end
      end
      prev = stim_ws[i];
      i = j;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (left_data !== '0)  begin n_bad++; $display("FAIL reset_left: got %h, required 0", left_data); end
    n_cmp++; if (right_data !== '0) begin n_bad++; $display("FAIL reset_right: got %h, required 0", right_data); end
    n_cmp++; if (valid !== 1'b0)    begin n_bad++; $display("FAIL reset_valid: got %b, required 0", valid); end
    n_cmp++; if (overrun !== 1'b0)  begin n_bad++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
  endtask

  task automatic test_stream();
    do_reset();
    ready = 1'b1;
    add_run(1'b1, SW, '0);
    repeat (3) add_frame(24'hA5A5A5, 24'h5A5A5A);
    send_pending();
    wait_cycles(8);
    build_expected();
    n_cmp++; if (cap_l.size() != exp_l.size()) begin n_bad++; $display("FAIL stream_count: got %0d pairs, required %0d", cap_l.size(), exp_l.size()); end
    for (int i = 0; i < exp_l.size() && i < cap_l.size(); i++) begin
      n_cmp++;
      if (cap_l[i] !== exp_l[i] || cap_r[i] !== exp_r[i]) begin
        n_bad++; $display("FAIL stream_pair%0d: got L=%h R=%h, required L=%h R=%h", i, cap_l[i], cap_r[i], exp_l[i], exp_r[i]);
      end
    end
    n_cmp++; if (cap_l.size() > 0 && cap_l[0] !== 24'hA5A5A5) begin n_bad++; $display("FAIL stream_left_const: got %h, required a5a5a5", cap_l[0]); end
    n_cmp++; if (valid_cycles != exp_l.size()) begin n_bad++; $display("FAIL stream_valid_width: got %0d valid cycles, required %0d", valid_cycles, exp_l.size()); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL stream_overrun: got %b, required 0", overrun); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL stream_frame_err: got %b, required 0", frame_err); end
  endtask

  task automatic test_random();
    do_reset();
    rand_ready = 1'b1;
    add_run(1'b1, $urandom_range(4, SW), '0);
    repeat (4) add_frame(DW'($urandom()), DW'($urandom()));
    send_pending();
    rand_ready = 1'b0;
    ready = 1'b1;
    wait_cycles(8);
    build_expected();
    n_cmp++; if (cap_l.size() != exp_l.size()) begin n_bad++; $display("FAIL random_count: got %0d pairs, required %0d", cap_l.size(), exp_l.size()); end
    for (int i = 0; i < exp_l.size() && i < cap_l.size(); i++) begin
      n_cmp++;
      if (cap_l[i] !== exp_l[i] || cap_r[i] !== exp_r[i]) begin
        n_bad++; $display("FAIL random_pair%0d: got L=%h R=%h, required L=%h R=%h", i, cap_l[i], cap_r[i], exp_l[i], exp_r[i]);
      end
    end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL random_overrun: got %b, required 0", overrun); end
  endtask

  task automatic test_midstart();
    do_reset();
    ready = 1'b1;
    add_run(1'b1, 15, DW'($urandom()));
    repeat (2) add_frame(DW'($urandom()), DW'($urandom()));
    send_pending();
    wait_cycles(8);
    build_expected();
    n_cmp++; if (cap_l.size() != exp_l.size()) begin n_bad++; $display("FAIL midstart_count: got %0d pairs, required %0d", cap_l.size(), exp_l.size()); end
    for (int i = 0; i < exp_l.size() && i < cap_l.size(); i++) begin
      n_cmp++;
      if (cap_l[i] !== exp_l[i] || cap_r[i] !== exp_r[i]) begin
        n_bad++; $display("FAIL midstart_pair%0d: got L=%h R=%h, required L=%h R=%h", i, cap_l[i], cap_r[i], exp_l[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_overrun_and_reset();
    do_reset();
    add_run(1'b1, SW, '0);
    add_frame(DW'($urandom()), DW'($urandom()));
    send_pending();
    wait_cycles(8);
    build_expected();
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL ovr_f1_valid: got %b, required 1", valid); end
    n_cmp++; if (left_data !== exp_l[0] || right_data !== exp_r[0]) begin n_bad++; $display("FAIL ovr_f1_data: got L=%h R=%h, required L=%h R=%h", left_data, right_data, exp_l[0], exp_r[0]); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_f1_overrun: got %b, required 0", overrun); end
    add_frame(DW'($urandom()), DW'($urandom()));
    send_pending();
    wait_cycles(8);
    build_expected();
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL ovr_f2_valid: got %b, required 1", valid); end
    n_cmp++; if (left_data !== exp_l[1] || right_data !== exp_r[1]) begin n_bad++; $display("FAIL ovr_f2_data: got L=%h R=%h, required L=%h R=%h", left_data, right_data, exp_l[1], exp_r[1]); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_f2_overrun: got %b, required 1", overrun); end
    // Abort halfway through the next left word with a single-cycle reset.
    add_run(1'b0, 11, DW'($urandom()));
    send_pending();
    rst = 1'b1;
    @(posedge mclk); #1;
    rst = 1'b0;
    n_cmp++; if (left_data !== '0 || right_data !== '0) begin n_bad++; $display("FAIL rst_mid_data: got L=%h R=%h, required 0/0", left_data, right_data); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b, required 0", valid); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL rst_mid_overrun: got %b, required 0", overrun); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL rst_mid_frame_err: got %b, required 0", frame_err); end
    clear_stream();
    ready = 1'b1;
    add_run(1'b0, SW - 11, '0);
    add_run(1'b1, SW, DW'($urandom()));
    repeat (2) add_frame(DW'($urandom()), DW'($urandom()));
    send_pending();
    wait_cycles(8);
    build_expected();
    n_cmp++; if (cap_l.size() != exp_l.size()) begin n_bad++; $display("FAIL rst_resync_count: got %0d pairs, required %0d", cap_l.size(), exp_l.size()); end
    for (int i = 0; i < exp_l.size() && i < cap_l.size(); i++) begin
      n_cmp++;
      if (cap_l[i] !== exp_l[i] || cap_r[i] !== exp_r[i]) begin
        n_bad++; $display("FAIL rst_resync_pair%0d: got L=%h R=%h, required L=%h R=%h", i, cap_l[i], cap_r[i], exp_l[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_frame_err();
    do_reset();
    ready = 1'b1;
    add_run(1'b1, SW, '0);
    send_pending();
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL ferr_before: got %b, required 0", frame_err); end
    add_run(1'b0, 11, DW'($urandom()));
    add_run(1'b1, SW, DW'($urandom()));
    repeat (2) add_frame(DW'($urandom()), DW'($urandom()));
    send_pending();
    wait_cycles(8);
    build_expected();
    n_cmp++; if (frame_err !== FE_EXP) begin n_bad++; $display("FAIL ferr_flag: got %b, required %b", frame_err, FE_EXP); end
    n_cmp++; if (cap_l.size() != exp_l.size()) begin n_bad++; $display("FAIL ferr_count: got %0d pairs, required %0d", cap_l.size(), exp_l.size()); end
    for (int i = 0; i < exp_l.size() && i < cap_l.size(); i++) begin
      n_cmp++;
      if (cap_l[i] !== exp_l[i] || cap_r[i] !== exp_r[i]) begin
        n_bad++; $display("FAIL ferr_pair%0d: got L=%h R=%h, required L=%h R=%h", i, cap_l[i], cap_r[i], exp_l[i], exp_r[i]);
      end
    end
  endtask

  // ready rises exactly for the edge that loads the second pair: 2 sync flops,
  // edge register, then one cycle to load after the last right data tick.
  task automatic test_collision();
    logic [DW-1:0] l1, r1, l2, r2;
    l1 = DW'($urandom()); r1 = DW'($urandom());
    l2 = DW'($urandom()); r2 = DW'($urandom());
    do_reset();
    add_run(1'b1, SW, '0);
    add_frame(l1, r1);
    send_pending();
    wait_cycles(8);
    n_cmp++; if (valid !== 1'b1 || left_data !== l1) begin n_bad++; $display("FAIL coll_first: got valid=%b L=%h, required 1/%h", valid, left_data, l1); end
    add_run(1'b0, SW, l2);
    add_run(1'b1, DW + 1, r2);
    send_pending();
    wait_cycles(2);
    n_cmp++; if (valid !== 1'b1 || left_data !== l1) begin n_bad++; $display("FAIL coll_pre: got valid=%b L=%h, required 1/%h", valid, left_data, l1); end
    ready = 1'b1;
    wait_cycles(1);
    ready = 1'b0;
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL coll_valid: got %b, required 1", valid); end
    n_cmp++; if (left_data !== l2 || right_data !== r2) begin n_bad++; $display("FAIL coll_data: got L=%h R=%h, required L=%h R=%h", left_data, right_data, l2, r2); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL coll_overrun: got %b, required 0", overrun); end
    add_run(1'b1, SW - DW - 1, '0);
    send_pending();
    ready = 1'b1;
    wait_cycles(8);
    build_expected();
    n_cmp++; if (cap_l.size() != exp_l.size()) begin n_bad++; $display("FAIL coll_count: got %0d pairs, required %0d", cap_l.size(), exp_l.size()); end
    for (int i = 0; i < exp_l.size() && i < cap_l.size(); i++) begin
      n_cmp++;
      if (cap_l[i] !== exp_l[i] || cap_r[i] !== exp_r[i]) begin
        n_bad++; $display("FAIL coll_pair%0d: got L=%h R=%h, required L=%h R=%h", i, cap_l[i], cap_r[i], exp_l[i], exp_r[i]);
      end
    end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL coll_drained: got valid=%b, required 0", valid); end
  endtask

  initial begin
    @(posedge mclk); #1;
    test_reset();
    test_stream();
    test_random();
    test_midstart();
    test_overrun_and_reset();
    test_frame_err();
    test_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_slave_rx.md
I2S_SLAVE_RX -- requirements
Module: i2s_slave_rx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 24: audio bits captured per channel, MSB first.
REQ-002 The block SHALL have parameter SLOT_WIDTH, default 32: sclk periods per channel slot, giving sclk/ws ratio 2*SLOT_WIDTH = 64.
REQ-003 The block SHALL have port mclk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port sclk_in, input, 1 bit: external bit clock, asynchronous to mclk.
REQ-006 The block SHALL have port ws_in, input, 1 bit: external word select; 0 = left, 1 = right.
REQ-007 The block SHALL have port sd_in, input, 1 bit: serial data from the external master.
REQ-008 The block SHALL have port left_data, output, DATA_WIDTH bits: captured left sample.
REQ-009 The block SHALL have port right_data, output, DATA_WIDTH bits: captured right sample.
REQ-010 The block SHALL have port valid, output, 1 bit: left_data/right_data hold an unconsumed stereo pair.
REQ-011 The block SHALL have port ready, input, 1 bit: consumer accepts the pair when valid and ready are both 1 on an mclk edge.
REQ-012 The block SHALL have port overrun, output, 1 bit: sticky flag, set when a new pair arrives while valid is still 1.
REQ-013 The block SHALL have port frame_err, output, 1 bit: sticky framing-error flag, present only with the macro (REQ-030).

Function
REQ-014 The block SHALL pass sclk_in, ws_in and sd_in each through a 2-flop synchronizer, then one edge-detect register.
REQ-015 The block SHALL require mclk/sclk >= 4; behaviour below this ratio is undefined.
REQ-016 The block SHALL sample the synchronized sd and ws only on a detected sclk rising edge ("bit tick").
REQ-017 The block SHALL implement states SYNC, DELAY, SHIFT and PAD.
REQ-018 SYNC: the block SHALL ignore data until a ws 1->0 transition is seen at a bit tick, then go to DELAY.
REQ-019 DELAY: at the next bit tick (the I2S one-bit delay), the block SHALL go to SHIFT with bit count 0.
REQ-020 SHIFT: at each bit tick the block SHALL shift sd into the current channel's register, MSB first, and increment the count.
REQ-021 SHIFT: when the count reaches DATA_WIDTH, the block SHALL go to PAD.
REQ-022 PAD: the block SHALL ignore bits until ws toggles at a bit tick, then go to DELAY for the other channel.
REQ-023 When the right channel completes DATA_WIDTH bits, the block SHALL load left_data/right_data in the next mclk cycle and set valid in that same cycle.
REQ-024 valid SHALL clear in the cycle after a valid && ready handshake.
REQ-025 If a new pair completes while valid = 1, the block SHALL overwrite the data, keep valid = 1 and set overrun.
REQ-026 If a pair completes in the same cycle as a handshake, the block SHALL load the new pair, keep valid = 1 and leave overrun unchanged.
REQ-027 If ws toggles during SHIFT, the block SHALL discard the partial word, set frame_err (macro on only), go to DELAY for the new channel, and not emit the pair.
REQ-028 A left word SHALL pair only with the right word immediately following it.

Reset
REQ-029 While rst = 1, the block SHALL set: state SYNC, all synchronizers and counters 0, left_data = 0, right_data = 0, valid = 0, overrun = 0, frame_err = 0; rst mid-frame aborts capture and requires a new ws 1->0 transition.

Configuration
REQ-030 With I2S_RX_FRAME_CHECK_EN defined, the block SHALL implement frame_err per REQ-027; without it, frame_err SHALL be tied to 0, with resync still occurring but no flag logic.

Structure
REQ-031 The state enumeration and default DATA_WIDTH/SLOT_WIDTH constants SHALL live in shared package i2s_pkg, also used by the transmit side.
REQ-032 The synchronizer-plus-edge-detect SHALL be sub-module i2s_edge_sync, instantiated for sclk; ws and sd use plain 2-flop sync plus one delay register, aligned to the sclk path.

Verification
REQ-033 The bench SHALL drive 64-ratio frames, mclk/sclk = 4, left = 0xA5A5A5, right = 0x5A5A5A, ready = 1 -> valid pulses 1 cycle per frame with exact data and overrun = 0.
REQ-034 The bench SHALL hold ready = 0 for 2 frames -> after frame 1, valid = 1 with frame-1 data; after frame 2, data = frame-2 values and overrun = 1.
REQ-035 The bench SHALL start streaming mid right slot -> no valid until after the first full left+right pair following a ws 1->0 transition.
REQ-036 The bench SHALL toggle ws after 10 left bits, with the macro on -> frame_err = 1, no pair emitted, next complete pair captured correctly; with the macro off -> frame_err stays 0.
REQ-037 The bench SHALL assert rst for 1 cycle mid-left-word -> all outputs 0 next cycle, resync on the next ws 1->0 transition.
REQ-038 The bench SHALL assert ready in the cycle a new pair completes while valid = 1 -> new data loaded, valid stays 1, overrun stays 0.
